// File: rtl/counter_load_scheduler.sv
// counter_load_scheduler
// Round-robin owner of a shared loadable up-counter. Each grant runs one
// transaction: load the requester's start value, let the counter run for
// WINDOW cycles, sample the count, pulse done to the owner.
// All outputs are registered or decoded from registered state only.
module counter_load_scheduler #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int WINDOW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0]      cnt_out,
  output logic                  cnt_load,
  output logic [WIDTH-1:0]      cnt_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic                  busy
);

  localparam int         PW    = $clog2(NREQ);
  localparam logic [7:0] TLAST = 8'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q,  state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  gnt_q,    gnt_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic [7:0]       timer_q,  timer_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             win_vld;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    cand;
  logic [WIDTH-1:0] win_slice;

  // Round-robin search from rr_ptr+1 upward. Walking the candidates from
  // lowest priority to highest lets the last hit be the winner, no break.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = PW'((int'(rr_ptr_q) + k) % NREQ);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Winner's start value, captured only on the grant edge.
  always_comb begin
    win_slice = req_data[int'(win_idx)*WIDTH +: WIDTH];
  end

  // Next-state logic; arbitration shares IDLE and DONE so a pending
  // request moves straight from DONE to LOAD without an idle gap.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    data_d   = data_q;
    timer_d  = timer_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (win_vld) begin
          state_d  = S_LOAD;
          gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          rr_ptr_d = win_idx;
          data_d   = win_slice;
        end else begin
          state_d  = S_IDLE;
          gnt_d    = '0;
        end
      end
      S_LOAD: begin
        timer_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        timer_d = timer_q + 8'd1;
        if (timer_q == TLAST) begin
          // Counter was loaded at the LOAD edge and has stepped
          // WINDOW-1 times by now.
          result_d = cnt_out;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; async reset aborts any transaction without a done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= PW'(NREQ - 1);
      gnt_q    <= '0;
      data_q   <= '0;
      timer_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      data_q   <= data_d;
      timer_q  <= timer_d;
      result_q <= result_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    cnt_load = (state_q == S_LOAD);
    cnt_data = (state_q == S_LOAD) ? data_q : '0;
    gnt      = gnt_q;
    done     = (state_q == S_DONE) ? gnt_q : '0;
    result   = result_q;
    busy     = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_counter_load_scheduler.sv
// Bench for counter_load_scheduler: table-driven single transactions,
// hand-written multi-cycle sequences, then random traffic against a
// transaction-age reference model.
module tb_counter_load_scheduler;
  localparam int NREQ = 4, WIDTH = 8, WINDOW = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [WIDTH-1:0]      cnt_out = '0;
  logic                  cnt_load;
  logic [WIDTH-1:0]      cnt_data;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result;
  logic                  busy;

  counter_load_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .cnt_out(cnt_out),
    .cnt_load(cnt_load), .cnt_data(cnt_data), .gnt(gnt), .done(done),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // The shared counter, never reset.
  always @(posedge clk) cnt_out <= cnt_load ? cnt_data : cnt_out + 1'b1;

  int errors = 0, checks = 0, cyc = 0, gnt_cycles = 0;
  logic prev_load = 1'b0;

  typedef struct { int cyc; int who; logic [WIDTH-1:0] dat; } ev_t;
  ev_t load_log[$];
  ev_t done_log[$];

  // Reference model: owner index, cycles since grant (0 = LOAD cycle,
  // 1..WINDOW = run, WINDOW+1 = done), last served index, start, result.
  int               m_owner, m_age, m_ptr;
  logic [WIDTH-1:0] m_start, m_result;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_ptr = NREQ - 1; m_start = '0; m_result = '0;
  endtask

  task automatic model_check();
    int eg;
    int el;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    el = (m_owner >= 0 && m_age == 0) ? 1 : 0;
    chk("gnt", gnt, eg);
    chk("busy", busy, (m_owner >= 0) ? 1 : 0);
    chk("cnt_load", cnt_load, el);
    chk("cnt_data", cnt_data, el ? int'(m_start) : 0);
    chk("done", done, (m_owner >= 0 && m_age == WINDOW + 1) ? eg : 0);
    chk("result", result, m_result);
    chk("gnt_onehot0", $onehot0(gnt), 1);
    chk("load_consec", prev_load & cnt_load, 0);
  endtask

  task automatic model_step();
    if (m_owner >= 0 && m_age == WINDOW)
      m_result = WIDTH'(int'(m_start) + WINDOW - 1);
    if (m_owner < 0 || m_age == WINDOW + 1) begin
      m_owner = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (req[i]) begin m_owner = i; break; end
      end
      if (m_owner >= 0) begin
        m_ptr = m_owner;
        m_start = req_data[m_owner*WIDTH +: WIDTH];
        m_age = 0;
      end
    end else begin
      m_age++;
    end
  endtask

  // One clock: check at negedge, advance model, return at posedge+1.
  task automatic tick();
    @(negedge clk);
    model_check();
    if (cnt_load) load_log.push_back('{cyc, oh2idx(gnt), cnt_data});
    if (done != 0) done_log.push_back('{cyc, oh2idx(done), result});
    if (gnt != 0) gnt_cycles++;
    prev_load = cnt_load;
    model_step();
    cyc++;
    @(posedge clk); #1;
  endtask

  // Async reset pulse; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_load", cnt_load, 0);
    chk("rst_data", cnt_data, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    prev_load = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic clear_logs();
    load_log.delete(); done_log.delete(); gnt_cycles = 0;
  endtask

  typedef struct {
    logic [NREQ-1:0]       rq;
    logic [NREQ*WIDTH-1:0] d;
    int                    win;
    logic [WIDTH-1:0]      res;
  } vec_t;
  vec_t tbl[4];

  initial begin
    tbl[0] = '{4'b0100, {8'h11, 8'h6C, 8'h22, 8'h33}, 2, 8'h70};
    tbl[1] = '{4'b0001, {8'h01, 8'h02, 8'h03, 8'hFE}, 0, 8'h02};
    tbl[2] = '{4'b1010, {8'h55, 8'h44, 8'h80, 8'h66}, 1, 8'h84};
    tbl[3] = '{4'b1000, {8'hFF, 8'h00, 8'h00, 8'h00}, 3, 8'h03};

    #2;
    // Single transactions from reset; req_data is scrambled after the
    // grant edge and must be ignored.
    foreach (tbl[r]) begin
      do_reset();
      clear_logs();
      req = tbl[r].rq; req_data = tbl[r].d;
      tick();
      req = '0; req_data = ~tbl[r].d;
      repeat (WINDOW + 3) tick();
      chk("tbl_loads", load_log.size(), 1);
      chk("tbl_dones", done_log.size(), 1);
      chk("tbl_gnt_cycles", gnt_cycles, WINDOW + 2);
      if (load_log.size() >= 1) begin
        chk("tbl_winner", load_log[0].who, tbl[r].win);
        chk("tbl_load_data", load_log[0].dat, tbl[r].d[tbl[r].win*WIDTH +: WIDTH]);
      end
      if (done_log.size() >= 1) begin
        chk("tbl_done_who", done_log[0].who, tbl[r].win);
        chk("tbl_result", done_log[0].dat, tbl[r].res);
        chk("tbl_done_cyc", done_log[0].cyc - load_log[0].cyc, WINDOW + 1);
      end
    end

    // All four held: order 0,1,2,3,0, LOADs WINDOW+2 apart.
    begin
      int exp_who[5] = '{0, 1, 2, 3, 0};
      logic [WIDTH-1:0] exp_res[4] = '{8'h0E, 8'h18, 8'h22, 8'h2C};
      do_reset();
      clear_logs();
      req = 4'hF; req_data = {8'd40, 8'd30, 8'd20, 8'd10};
      repeat (5 * (WINDOW + 2) + 1) tick();
      chk("rr4_loads", load_log.size() >= 5, 1);
      chk("rr4_dones", done_log.size() >= 4, 1);
      for (int i = 0; i < 5 && i < load_log.size(); i++) begin
        chk("rr4_order", load_log[i].who, exp_who[i]);
        if (i > 0) chk("rr4_spacing", load_log[i].cyc - load_log[i-1].cyc, WINDOW + 2);
      end
      for (int i = 0; i < 4 && i < done_log.size(); i++)
        chk("rr4_result", done_log[i].dat, exp_res[i]);
    end

    // Two held: strict alternation.
    do_reset();
    clear_logs();
    req = 4'b0011; req_data = $urandom;
    repeat (6 * (WINDOW + 2)) tick();
    chk("alt_loads", load_log.size() >= 5, 1);
    for (int i = 0; i < load_log.size(); i++)
      chk("alt_order", load_log[i].who, i % 2);

    // Drop req[3] during RUN: transaction completes, then 1 is served.
    do_reset();
    clear_logs();
    req = 4'b1000; req_data = {8'h50, 8'h00, 8'h77, 8'h00};
    tick();
    req = 4'b1010;
    repeat (2) tick();
    req = 4'b0010;
    repeat (WINDOW + 4) tick();
    chk("drop_dones", done_log.size() >= 1, 1);
    if (done_log.size() >= 1) begin
      chk("drop_done_who", done_log[0].who, 3);
      chk("drop_result", done_log[0].dat, 8'h54);
    end
    chk("drop_loads", load_log.size(), 2);
    if (load_log.size() >= 2) begin
      chk("drop_next", load_log[1].who, 1);
      chk("drop_gap", load_log[1].cyc - load_log[0].cyc, WINDOW + 2);
    end

    // Reset in the third RUN cycle of requester 2: no done, then 0 first.
    do_reset();
    clear_logs();
    req = 4'b0100; req_data = {8'h00, 8'h33, 8'h00, 8'h00};
    repeat (4) tick();
    chk("abort_busy", busy, 1);
    do_reset();
    chk("abort_no_done", done_log.size(), 0);
    clear_logs();
    req = 4'b0101; req_data = {8'h00, 8'h20, 8'h00, 8'h10};
    repeat (3) tick();
    chk("abort_loads", load_log.size(), 1);
    if (load_log.size() >= 1) chk("abort_first", load_log[0].who, 0);
    chk("abort_no_done2", done_log.size(), 0);

    // Random traffic against the model, with one async reset mid-run.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      req_data = $urandom;
      if (n == 200) do_reset();
      tick();
    end
    req = '0;
    repeat (WINDOW + 4) tick();
    chk("final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
